// File: rtl/miner_nonce_dispatcher_if.sv
// Handshake between the nonce dispatcher (master) and one miner core (slave).
interface miner_nonce_dispatcher_if #(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256
);
  logic               hash_enable;
  logic [NONCE_W-1:0] nonce;
  logic               core_finished;
  logic [HASH_W-1:0]  core_hash;

  modport master (
    output hash_enable,
    output nonce,
    input  core_finished,
    input  core_hash
  );

  modport slave (
    input  hash_enable,
    input  nonce,
    output core_finished,
    output core_hash
  );
endinterface

// File: rtl/miner_nonce_dispatcher.sv
// Sweeps a nonce range on one miner core, one hash at a time, and compares each
// returned hash against a latched target; reports found / exhausted / timeout.
module miner_nonce_dispatcher #(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256,
  parameter int unsigned TIMEOUT = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NONCE_W-1:0]       nonce_first,
  input  logic [NONCE_W-1:0]       nonce_last,
  input  logic [HASH_W-1:0]        target,
  miner_nonce_dispatcher_if.master core,
  output logic                     busy,
  output logic                     found,
  output logic [NONCE_W-1:0]       nonce_found,
  output logic                     exhausted,
  output logic                     timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // The counter reads k during the (k+1)th WAIT cycle; leaving on TIMEOUT-2 puts
  // timeout_err exactly TIMEOUT cycles after the hash_enable cycle.
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCheck,
    StFound,
    StExhaust,
    StErr
  } state_e;

  state_e             state_q;
  logic               hash_enable_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] last_q;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_q;
  logic [CntW-1:0]    wait_cnt_q;

  assign core.hash_enable = hash_enable_q;
  assign core.nonce       = nonce_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      hash_enable_q <= 1'b0;
      nonce_q       <= '0;
      last_q        <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      wait_cnt_q    <= '0;
      busy          <= 1'b0;
      found         <= 1'b0;
      nonce_found   <= '0;
      exhausted     <= 1'b0;
      timeout_err   <= 1'b0;
    end else if (abort) begin
      state_q       <= StIdle;
      hash_enable_q <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      exhausted     <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      hash_enable_q <= 1'b0;
      unique case (state_q)
        StIdle, StFound, StExhaust, StErr: begin
          if (start) begin
            last_q      <= nonce_last;
            target_q    <= target;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            if (nonce_first > nonce_last) begin
              state_q   <= StExhaust;
              exhausted <= 1'b1;
            end else begin
              nonce_q       <= nonce_first;
              state_q       <= StLaunch;
              hash_enable_q <= 1'b1;
              busy          <= 1'b1;
            end
          end
        end
        StLaunch: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (core.core_finished) begin
            hash_q  <= core.core_hash;
            state_q <= StCheck;
          end else if (wait_cnt_q == WaitLast) begin
            state_q     <= StErr;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StCheck: begin
          if (hash_q < target_q) begin
            state_q     <= StFound;
            found       <= 1'b1;
            nonce_found <= nonce_q;
            busy        <= 1'b0;
          end else if (nonce_q == last_q) begin
            // Equality before increment: an all-ones last nonce never wraps to 0.
            state_q   <= StExhaust;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else begin
            nonce_q       <= nonce_q + 1'b1;
            state_q       <= StLaunch;
            hash_enable_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Bench for miner_nonce_dispatcher: scripted and random sweeps against a
// queue-based sweep model, with a behavioural miner core responder.
module tb_miner_nonce_dispatcher;
  localparam int unsigned NW = 32;
  localparam int unsigned HW = 256;
  localparam int unsigned TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [NW-1:0] nonce_first;
  logic [NW-1:0] nonce_last;
  logic [HW-1:0] target;
  logic          busy;
  logic          found;
  logic [NW-1:0] nonce_found;
  logic          exhausted;
  logic          timeout_err;

  miner_nonce_dispatcher_if #(.NONCE_W(NW), .HASH_W(HW)) core ();

  miner_nonce_dispatcher #(.NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .target      (target),
    .core        (core),
    .busy        (busy),
    .found       (found),
    .nonce_found (nonce_found),
    .exhausted   (exhausted),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Core responder: answers each launch resp_lat cycles later with the next queued hash.
  bit            resp_en;
  int            resp_lat;
  int            countdown = -1;
  logic [HW-1:0] hash_q[$];
  logic [NW-1:0] launch_log[$];

  initial begin
    core.core_finished = 1'b0;
    core.core_hash     = '0;
    forever begin
      @(negedge clk);
      core.core_finished = 1'b0;
      if (core.hash_enable === 1'b1) begin
        launch_log.push_back(core.nonce);
        countdown = resp_en ? resp_lat : -1;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          core.core_finished = 1'b1;
          if (hash_q.size() > 0) core.core_hash = hash_q.pop_front();
          else core.core_hash = '1;
          countdown = -1;
        end
      end
    end
  end

  // Sweep model: 1 = found, 2 = exhausted.
  logic [NW-1:0] exp_launch[$];
  int            exp_kind;
  logic [NW-1:0] exp_win;

  function automatic void ref_sweep(logic [NW-1:0] first, logic [NW-1:0] last,
                                    logic [HW-1:0] tgt);
    longint unsigned n;
    logic [HW-1:0]   h;
    exp_launch.delete();
    exp_kind = 2;
    exp_win  = '0;
    if (first > last) return;
    n = 64'(first);
    for (int i = 0; i < 100000; i++) begin
      exp_launch.push_back(NW'(n));
      h = (i < hash_q.size()) ? hash_q[i] : '1;
      if (h < tgt) begin
        exp_kind = 1;
        exp_win  = NW'(n);
        return;
      end
      if (n == 64'(last)) return;
      n++;
    end
  endfunction

  function automatic logic [HW-1:0] rand_hash();
    logic [HW-1:0] r = '0;
    for (int i = 0; i < HW / 32; i++) r = (r << 32) | HW'($urandom);
    return r;
  endfunction

  function automatic int obs_kind();
    return found ? 1 : exhausted ? 2 : timeout_err ? 3 : 0;
  endfunction

  task automatic start_job(input logic [NW-1:0] f, input logic [NW-1:0] l,
                           input logic [HW-1:0] t);
    @(negedge clk);
    nonce_first = f;
    nonce_last  = l;
    target      = t;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!(found || exhausted || timeout_err) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({core.hash_enable, core.nonce, busy, found, nonce_found, exhausted, timeout_err} !== '0)
    begin
      n_errors++;
      $display("FAIL reset_outputs: he=%b nonce=%h busy=%b found=%b nf=%h ex=%b to=%b, want all 0",
               core.hash_enable, core.nonce, busy, found, nonce_found, exhausted, timeout_err);
    end
    rst = 1'b0;
    // Mid-job reset behaves like power-on reset.
    hash_q.delete(); launch_log.delete(); resp_lat = 10;
    start_job(32'd7, 32'd9, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({core.hash_enable, core.nonce, busy, found, nonce_found, exhausted, timeout_err} !== '0)
    begin
      n_errors++;
      $display("FAIL midjob_reset: he=%b nonce=%h busy=%b found=%b ex=%b to=%b, want all 0",
               core.hash_enable, core.nonce, busy, found, exhausted, timeout_err);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (launch_log.size() !== 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midjob_reset_quiet: launches=%0d busy=%b, want 1 and 0",
               launch_log.size(), busy);
    end
  endtask

  task automatic test_found_first();
    hash_q.delete(); launch_log.delete(); resp_lat = 10;
    hash_q.push_back(256'h1234);
    ref_sweep(32'd5, 32'd7, '1);
    start_job(32'd5, 32'd7, '1);
    n_checks++;
    if (core.hash_enable !== 1'b1 || core.nonce !== 32'd5) begin
      n_errors++;
      $display("FAIL found_launch_latency: he=%b nonce=%h, want 1 and 5", core.hash_enable,
               core.nonce);
    end
    wait_done();
    n_checks++;
    if (obs_kind() !== exp_kind || nonce_found !== exp_win || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL found_result: kind=%0d nf=%h busy=%b, want kind=%0d nf=%h busy=0",
               obs_kind(), nonce_found, busy, exp_kind, exp_win);
    end
    n_checks++;
    if (launch_log.size() !== exp_launch.size()) begin
      n_errors++;
      $display("FAIL found_launches: got %0d want %0d", launch_log.size(), exp_launch.size());
    end
  endtask

  task automatic test_exhaust_range();
    hash_q.delete(); launch_log.delete(); resp_lat = 4;
    for (int i = 0; i < 3; i++) hash_q.push_back(rand_hash());
    ref_sweep(32'd0, 32'd2, '0);
    start_job(32'd0, 32'd2, '0);
    wait_done();
    n_checks++;
    if (obs_kind() !== exp_kind || found !== 1'b0) begin
      n_errors++;
      $display("FAIL exhaust_result: kind=%0d found=%b, want kind=%0d found=0", obs_kind(),
               found, exp_kind);
    end
    n_checks++;
    if (launch_log.size() !== exp_launch.size()) begin
      n_errors++;
      $display("FAIL exhaust_launch_count: got %0d want %0d", launch_log.size(),
               exp_launch.size());
    end
    for (int i = 0; i < launch_log.size() && i < exp_launch.size(); i++) begin
      n_checks++;
      if (launch_log[i] !== exp_launch[i]) begin
        n_errors++;
        $display("FAIL exhaust_launch_nonce[%0d]: got %h want %h", i, launch_log[i],
                 exp_launch[i]);
      end
    end
  endtask

  task automatic test_no_wrap();
    logic [HW-1:0] t = rand_hash();
    hash_q.delete(); launch_log.delete(); resp_lat = 2;
    hash_q.push_back('1);
    ref_sweep('1, '1, t);
    start_job('1, '1, t);
    wait_done();
    n_checks++;
    if (obs_kind() !== exp_kind || launch_log.size() !== exp_launch.size()) begin
      n_errors++;
      $display("FAIL no_wrap_result: kind=%0d launches=%0d, want kind=%0d launches=%0d",
               obs_kind(), launch_log.size(), exp_kind, exp_launch.size());
    end
    n_checks++;
    if (core.nonce !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL no_wrap_nonce: got %h want ffffffff", core.nonce);
    end
  endtask

  task automatic test_timeout();
    int c = 0;
    hash_q.delete(); launch_log.delete(); resp_en = 1'b0;
    start_job(32'd0, 32'd5, '1);
    while (timeout_err !== 1'b1 && c < int'(TO) + 50) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c !== int'(TO)) begin
      n_errors++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", c, TO);
    end
    n_checks++;
    if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_flags: busy=%b found=%b ex=%b, want 0 0 0", busy, found, exhausted);
    end
    resp_en = 1'b1; resp_lat = 3;
    hash_q.push_back(256'h0);
    ref_sweep(32'd1, 32'd1, 256'h1);
    start_job(32'd1, 32'd1, 256'h1);
    wait_done();
    n_checks++;
    if (obs_kind() !== exp_kind || nonce_found !== exp_win) begin
      n_errors++;
      $display("FAIL timeout_recover: kind=%0d nf=%h, want kind=%0d nf=%h", obs_kind(),
               nonce_found, exp_kind, exp_win);
    end
  endtask

  task automatic test_abort();
    hash_q.delete(); launch_log.delete(); resp_lat = 10;
    hash_q.push_back('0);
    start_job(32'd20, 32'd25, '1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({busy, found, exhausted, timeout_err, core.hash_enable} !== 5'b0) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b found=%b ex=%b to=%b he=%b, want all 0", busy, found,
               exhausted, timeout_err, core.hash_enable);
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if ({busy, found, exhausted, timeout_err} !== 4'b0 || launch_log.size() !== 1) begin
      n_errors++;
      $display("FAIL abort_late_finish: busy=%b found=%b ex=%b launches=%0d, want 0 0 0 1",
               busy, found, exhausted, launch_log.size());
    end
    // Abort wins over start in the same cycle.
    @(negedge clk);
    nonce_first = 32'd20; nonce_last = 32'd25; target = '1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if (core.hash_enable !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_beats_start: he=%b busy=%b, want 0 0", core.hash_enable, busy);
    end
    hash_q.delete(); launch_log.delete(); resp_lat = 3;
    hash_q.push_back(256'h5);
    ref_sweep(32'd20, 32'd25, '1);
    start_job(32'd20, 32'd25, '1);
    wait_done();
    n_checks++;
    if (launch_log.size() < 1 || launch_log[0] !== exp_launch[0] || nonce_found !== exp_win) begin
      n_errors++;
      $display("FAIL abort_restart: launches=%0d nf=%h, want first launch %h nf=%h",
               launch_log.size(), nonce_found, exp_launch[0], exp_win);
    end
  endtask

  task automatic test_empty_range_and_busy_start();
    hash_q.delete(); launch_log.delete();
    start_job(32'd9, 32'd3, '1);
    n_checks++;
    if (exhausted !== 1'b1 || core.hash_enable !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_range: ex=%b he=%b busy=%b, want 1 0 0", exhausted,
               core.hash_enable, busy);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (launch_log.size() !== 0) begin
      n_errors++;
      $display("FAIL empty_range_launches: got %0d want 0", launch_log.size());
    end
    // A second start while busy must not disturb the running sweep.
    resp_lat = 12;
    for (int i = 0; i < 3; i++) hash_q.push_back(rand_hash());
    ref_sweep(32'd0, 32'd2, '0);
    start_job(32'd0, 32'd2, '0);
    repeat (4) @(negedge clk);
    start_job(32'd100, 32'd200, '1);
    wait_done();
    n_checks++;
    if (obs_kind() !== exp_kind || launch_log.size() !== exp_launch.size()) begin
      n_errors++;
      $display("FAIL busy_start_ignored: kind=%0d launches=%0d, want kind=%0d launches=%0d",
               obs_kind(), launch_log.size(), exp_kind, exp_launch.size());
    end
  endtask

  task automatic test_random();
    logic [NW-1:0] f;
    logic [NW-1:0] l;
    logic [HW-1:0] t;
    int            k;
    bit            ok;
    for (int it = 0; it < 25; it++) begin
      hash_q.delete(); launch_log.delete();
      resp_lat = int'($urandom_range(1, 12));
      k = int'($urandom_range(0, 6));
      l = (it % 4 == 0) ? NW'(32'hFFFF_FFFF - $urandom_range(0, 3)) : NW'($urandom);
      f = ($urandom_range(0, 5) == 0) ? l + NW'(1 + $urandom_range(0, 9)) : l - NW'(k);
      case ($urandom_range(0, 5))
        0:       t = '0;
        1:       t = '1;
        default: t = rand_hash();
      endcase
      for (int i = 0; i <= k + 10; i++) hash_q.push_back(rand_hash());
      ref_sweep(f, l, t);
      start_job(f, l, t);
      wait_done();
      n_checks++;
      if (obs_kind() !== exp_kind || (exp_kind == 1 && nonce_found !== exp_win)) begin
        n_errors++;
        $display("FAIL random[%0d]_result: kind=%0d nf=%h, want kind=%0d nf=%h", it, obs_kind(),
                 nonce_found, exp_kind, exp_win);
      end
      ok = (launch_log.size() == exp_launch.size());
      for (int i = 0; ok && i < launch_log.size(); i++) ok = (launch_log[i] == exp_launch[i]);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL random[%0d]_launches: got %0d launches want %0d (first=%h last=%h)", it,
                 launch_log.size(), exp_launch.size(), f, l);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    nonce_first = '0;
    nonce_last  = '0;
    target      = '0;
    resp_en     = 1'b1;
    resp_lat    = 3;
    test_reset();
    test_found_first();
    test_exhaust_range();
    test_no_wrap();
    test_timeout();
    test_abort();
    test_empty_range_and_busy_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
